// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID/EX pipeline register bundle: decode inputs, forwarding sources, EX outputs
// The stage is the slave; the surrounding pipeline (or bench) is the master.
interface id_ex_stage_if;
  logic        id_valid, id_is_load, id_rf_we, id_ram_we, id_is_branch, id_rs1_used, id_rs2_used;
  logic [31:0] id_pc, id_ext, id_rs1_data, id_rs2_data;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [1:0]  id_alua_sel, id_alub_sel, id_wd_sel;
  logic [3:0]  id_alu_op;
  logic [31:0] ex_alu_result;
  logic        ex_branch_taken;
  logic [4:0]  mem_rd;
  logic        mem_rf_we;
  logic [31:0] mem_fwd_data;
  logic [4:0]  wb_rd;
  logic        wb_rf_we;
  logic [31:0] wb_wd;
  logic        ex_valid, ex_is_load, ex_rf_we, ex_ram_we, ex_is_branch;
  logic [31:0] ex_pc, ex_ext, ex_rs1_data, ex_rs2_data;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_alua_sel, ex_alub_sel, ex_wd_sel;
  logic [3:0]  ex_alu_op;
  logic        stall_id;

  modport slave (
    input  id_valid, id_is_load, id_rf_we, id_ram_we, id_is_branch, id_rs1_used, id_rs2_used,
    input  id_pc, id_ext, id_rs1_data, id_rs2_data, id_rs1, id_rs2, id_rd,
    input  id_alua_sel, id_alub_sel, id_wd_sel, id_alu_op,
    input  ex_alu_result, ex_branch_taken, mem_rd, mem_rf_we, mem_fwd_data, wb_rd, wb_rf_we, wb_wd,
    output ex_valid, ex_is_load, ex_rf_we, ex_ram_we, ex_is_branch,
    output ex_pc, ex_ext, ex_rs1_data, ex_rs2_data, ex_rd,
    output ex_alua_sel, ex_alub_sel, ex_wd_sel, ex_alu_op, stall_id
  );

  modport master (
    output id_valid, id_is_load, id_rf_we, id_ram_we, id_is_branch, id_rs1_used, id_rs2_used,
    output id_pc, id_ext, id_rs1_data, id_rs2_data, id_rs1, id_rs2, id_rd,
    output id_alua_sel, id_alub_sel, id_wd_sel, id_alu_op,
    output ex_alu_result, ex_branch_taken, mem_rd, mem_rf_we, mem_fwd_data, wb_rd, wb_rf_we, wb_wd,
    input  ex_valid, ex_is_load, ex_rf_we, ex_ram_we, ex_is_branch,
    input  ex_pc, ex_ext, ex_rs1_data, ex_rs2_data, ex_rd,
    input  ex_alua_sel, ex_alub_sel, ex_wd_sel, ex_alu_op, stall_id
  );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall, branch flush and EX/MEM/WB forwarding
// Priority per edge: reset, then flush, then stall (bubble), then normal capture.
module id_ex_stage (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);
  typedef struct packed {
    logic        valid;
    logic        is_load;
    logic        rf_we;
    logic        ram_we;
    logic        is_branch;
    logic [31:0] pc;
    logic [31:0] ext;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic [1:0]  alua_sel;
    logic [1:0]  alub_sel;
    logic [1:0]  wd_sel;
    logic [3:0]  alu_op;
  } ex_reg_t;

  ex_reg_t ex_q, ex_d;
  logic    load_use;
  logic    flush;

  // A load in EX cannot forward its result yet, so only non-load EX writers are bypass sources.
  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf_data);
    logic [31:0] res;
    res = rf_data;
    if (r != 5'd0) begin
      if (ex_q.valid && ex_q.rf_we && !ex_q.is_load && ex_q.rd == r) res = bus.ex_alu_result;
      else if (bus.mem_rf_we && bus.mem_rd == r)                     res = bus.mem_fwd_data;
      else if (bus.wb_rf_we && bus.wb_rd == r)                       res = bus.wb_wd;
    end
    return res;
  endfunction

  assign flush    = bus.ex_branch_taken;
  assign load_use = bus.id_valid && ex_q.valid && ex_q.is_load && ex_q.rf_we && (ex_q.rd != 5'd0) &&
                    ((bus.id_rs1_used && bus.id_rs1 == ex_q.rd) ||
                     (bus.id_rs2_used && bus.id_rs2 == ex_q.rd));
  assign bus.stall_id = load_use && !flush && !rst;

  always_comb begin
    ex_d = '0;
    if (!flush && !load_use) begin
      ex_d.valid     = bus.id_valid;
      ex_d.is_load   = bus.id_is_load;
      ex_d.rf_we     = bus.id_rf_we && bus.id_valid;
      ex_d.ram_we    = bus.id_ram_we && bus.id_valid;
      ex_d.is_branch = bus.id_is_branch;
      ex_d.pc        = bus.id_pc;
      ex_d.ext       = bus.id_ext;
      ex_d.rs1_data  = fwd(bus.id_rs1, bus.id_rs1_data);
      ex_d.rs2_data  = fwd(bus.id_rs2, bus.id_rs2_data);
      ex_d.rd        = bus.id_rd;
      ex_d.alua_sel  = bus.id_alua_sel;
      ex_d.alub_sel  = bus.id_alub_sel;
      ex_d.wd_sel    = bus.id_wd_sel;
      ex_d.alu_op    = bus.id_alu_op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_is_load   = ex_q.is_load;
  assign bus.ex_rf_we     = ex_q.rf_we;
  assign bus.ex_ram_we    = ex_q.ram_we;
  assign bus.ex_is_branch = ex_q.is_branch;
  assign bus.ex_pc        = ex_q.pc;
  assign bus.ex_ext       = ex_q.ext;
  assign bus.ex_rs1_data  = ex_q.rs1_data;
  assign bus.ex_rs2_data  = ex_q.rs2_data;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_alua_sel  = ex_q.alua_sel;
  assign bus.ex_alub_sel  = ex_q.alub_sel;
  assign bus.ex_wd_sel    = ex_q.wd_sel;
  assign bus.ex_alu_op    = ex_q.alu_op;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - bench for id_ex_stage: directed scenarios plus randomized run against a reference model
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if bus ();
  id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic        valid, is_load, rf_we, ram_we, is_branch;
    logic [31:0] pc, ext, rs1, rs2;
    logic [4:0]  rd;
    logic [1:0]  alua, alub, wd;
    logic [3:0]  op;
  } ex_t;

  ex_t  exp_q;
  ex_t  got;
  assign got = {bus.ex_valid, bus.ex_is_load, bus.ex_rf_we, bus.ex_ram_we, bus.ex_is_branch,
                bus.ex_pc, bus.ex_ext, bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_rd,
                bus.ex_alua_sel, bus.ex_alub_sel, bus.ex_wd_sel, bus.ex_alu_op};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_valid = 0; bus.id_is_load = 0; bus.id_rf_we = 0; bus.id_ram_we = 0; bus.id_is_branch = 0;
    bus.id_rs1_used = 0; bus.id_rs2_used = 0; bus.id_pc = 0; bus.id_ext = 0;
    bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
    bus.id_alua_sel = 0; bus.id_alub_sel = 0; bus.id_wd_sel = 0; bus.id_alu_op = 0;
    bus.ex_alu_result = 0; bus.ex_branch_taken = 0;
    bus.mem_rd = 0; bus.mem_rf_we = 0; bus.mem_fwd_data = 0;
    bus.wb_rd = 0; bus.wb_rf_we = 0; bus.wb_wd = 0;
  endtask

  task automatic set_id(input logic ld, input logic rf, input logic ram, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] d1, input logic [31:0] d2);
    bus.id_valid = 1; bus.id_is_load = ld; bus.id_rf_we = rf; bus.id_ram_we = ram;
    bus.id_rd = rd; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rs1_used = 1; bus.id_rs2_used = 1;
    bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_pc = 32'h0000_0100; bus.id_ext = 32'h4;
  endtask

  // Reference: bypass sources listed in priority order; later scan over the list from lowest priority.
  function automatic logic [31:0] ref_operand(input logic [4:0] r, input logic [31:0] rf_data);
    logic        en [3];
    logic [4:0]  rd [3];
    logic [31:0] d  [3];
    logic [31:0] res;
    en[0] = exp_q.valid & exp_q.rf_we & ~exp_q.is_load; rd[0] = exp_q.rd;  d[0] = bus.ex_alu_result;
    en[1] = bus.mem_rf_we;                              rd[1] = bus.mem_rd; d[1] = bus.mem_fwd_data;
    en[2] = bus.wb_rf_we;                               rd[2] = bus.wb_rd;  d[2] = bus.wb_wd;
    res = rf_data;
    if (r != 0)
      for (int i = 2; i >= 0; i--)
        if (en[i] && rd[i] == r) res = d[i];
    return res;
  endfunction

  function automatic logic ref_hazard();
    logic [4:0] srcs [2];
    logic       used [2];
    logic       h;
    srcs[0] = bus.id_rs1; used[0] = bus.id_rs1_used;
    srcs[1] = bus.id_rs2; used[1] = bus.id_rs2_used;
    h = 0;
    if (bus.id_valid && exp_q.valid && exp_q.is_load && exp_q.rf_we && exp_q.rd != 0)
      foreach (srcs[i]) if (used[i] && srcs[i] == exp_q.rd) h = 1;
    return h;
  endfunction

  task automatic test_reset();
    clear_inputs();
    set_id(0, 1, 1, 5'd9, 5'd1, 5'd2, 32'hAA, 32'hBB);
    bus.id_pc = 32'h40;
    rst = 1;
    tick(); tick();
    n_total++; if (got !== '0) $display("FAIL reset_outputs got %h exp 0", got); else n_pass++;
    n_total++; if (bus.stall_id !== 1'b0) $display("FAIL reset_stall got %b exp 0", bus.stall_id); else n_pass++;
    rst = 0;
    tick();
    n_total++;
    if ({bus.ex_valid, bus.ex_rf_we, bus.ex_ram_we, bus.ex_pc, bus.ex_rd} !== {3'b111, 32'h40, 5'd9})
      $display("FAIL reset_release_capture got v%b we%b ram%b pc %h rd %0d exp 1 1 1 40 9",
               bus.ex_valid, bus.ex_rf_we, bus.ex_ram_we, bus.ex_pc, bus.ex_rd);
    else n_pass++;
  endtask

  task automatic test_ex_forward();
    clear_inputs();
    set_id(0, 1, 0, 5'd5, 5'd1, 5'd2, 32'h1, 32'h2);
    tick();
    bus.ex_alu_result = 32'h11;
    set_id(0, 1, 0, 5'd6, 5'd5, 5'd0, 32'h0, 32'h0);
    tick();
    n_total++; if (bus.ex_rs1_data !== 32'h11) $display("FAIL ex_forward got %h exp 00000011", bus.ex_rs1_data); else n_pass++;
  endtask

  task automatic test_priority();
    clear_inputs();
    set_id(0, 1, 0, 5'd7, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    bus.ex_alu_result = 32'hA;
    bus.mem_rf_we = 1; bus.mem_rd = 7; bus.mem_fwd_data = 32'hB;
    bus.wb_rf_we = 1;  bus.wb_rd = 7;  bus.wb_wd = 32'hC;
    set_id(0, 0, 0, 5'd8, 5'd0, 5'd7, 32'h0, 32'h55);
    tick();
    n_total++; if (bus.ex_rs2_data !== 32'hA) $display("FAIL prio_ex got %h exp 0000000a", bus.ex_rs2_data); else n_pass++;
    tick();
    n_total++; if (bus.ex_rs2_data !== 32'hB) $display("FAIL prio_mem got %h exp 0000000b", bus.ex_rs2_data); else n_pass++;
    bus.mem_rf_we = 0;
    tick();
    n_total++; if (bus.ex_rs2_data !== 32'hC) $display("FAIL prio_wb got %h exp 0000000c", bus.ex_rs2_data); else n_pass++;
    set_id(0, 1, 0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    bus.mem_rf_we = 1; bus.mem_rd = 0; bus.wb_rd = 0;
    set_id(0, 0, 0, 5'd8, 5'd0, 5'd0, 32'h77, 32'h88);
    tick();
    n_total++;
    if ({bus.ex_rs1_data, bus.ex_rs2_data} !== {32'h77, 32'h88})
      $display("FAIL prio_x0 got %h %h exp 00000077 00000088", bus.ex_rs1_data, bus.ex_rs2_data);
    else n_pass++;
  endtask

  task automatic test_load_use();
    clear_inputs();
    set_id(1, 1, 0, 5'd3, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    set_id(0, 1, 0, 5'd4, 5'd3, 5'd0, 32'h0, 32'h0);
    #1;
    n_total++; if (bus.stall_id !== 1'b1) $display("FAIL load_use_stall got %b exp 1", bus.stall_id); else n_pass++;
    tick();
    n_total++;
    if ({bus.ex_valid, bus.ex_rd} !== 6'd0) $display("FAIL load_use_bubble got v%b rd %0d exp 0 0", bus.ex_valid, bus.ex_rd);
    else n_pass++;
    n_total++; if (bus.stall_id !== 1'b0) $display("FAIL load_use_release got %b exp 0", bus.stall_id); else n_pass++;
    bus.mem_rf_we = 1; bus.mem_rd = 3; bus.mem_fwd_data = 32'h1234;
    tick();
    n_total++;
    if ({bus.ex_valid, bus.ex_rs1_data} !== {1'b1, 32'h1234})
      $display("FAIL load_use_mem_fwd got v%b %h exp 1 00001234", bus.ex_valid, bus.ex_rs1_data);
    else n_pass++;
  endtask

  task automatic test_flush();
    clear_inputs();
    set_id(1, 1, 0, 5'd3, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    set_id(0, 1, 1, 5'd4, 5'd3, 5'd0, 32'h0, 32'h0);
    bus.ex_branch_taken = 1;
    #1;
    n_total++; if (bus.stall_id !== 1'b0) $display("FAIL flush_stall got %b exp 0", bus.stall_id); else n_pass++;
    tick();
    n_total++;
    if ({bus.ex_valid, bus.ex_rf_we, bus.ex_ram_we} !== 3'b000)
      $display("FAIL flush_bubble got %b%b%b exp 000", bus.ex_valid, bus.ex_rf_we, bus.ex_ram_we);
    else n_pass++;
  endtask

  task automatic test_midstall_reset();
    clear_inputs();
    set_id(1, 1, 0, 5'd3, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    set_id(0, 1, 0, 5'd4, 5'd0, 5'd3, 32'h9, 32'h9);
    #1;
    n_total++; if (bus.stall_id !== 1'b1) $display("FAIL midstall_pre got %b exp 1", bus.stall_id); else n_pass++;
    rst = 1;
    tick();
    n_total++; if (got !== '0) $display("FAIL midstall_reset_outputs got %h exp 0", got); else n_pass++;
    n_total++; if (bus.stall_id !== 1'b0) $display("FAIL midstall_reset_stall got %b exp 0", bus.stall_id); else n_pass++;
    rst = 0;
  endtask

  task automatic test_back_to_back();
    logic exp_stall [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    clear_inputs();
    set_id(1, 1, 0, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    set_id(1, 1, 0, 5'd2, 5'd1, 5'd0, 32'h0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      if (c == 2) set_id(0, 1, 0, 5'd4, 5'd2, 5'd0, 32'h0, 32'h0);
      #1;
      n_total++;
      if (bus.stall_id !== exp_stall[c]) $display("FAIL b2b_stall cycle %0d got %b exp %b", c, bus.stall_id, exp_stall[c]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_random();
    ex_t  nxt;
    logic hz;
    logic exp_stall;
    clear_inputs();
    rst = 1; tick(); rst = 0;
    exp_q = '0;
    for (int c = 0; c < 400; c++) begin
      bus.id_valid = ($urandom_range(0, 3) != 0); bus.id_is_load = ($urandom_range(0, 2) == 0);
      bus.id_rf_we = $urandom_range(0, 1); bus.id_ram_we = $urandom_range(0, 1);
      bus.id_is_branch = ($urandom_range(0, 3) == 0);
      bus.id_rs1_used = $urandom_range(0, 1); bus.id_rs2_used = $urandom_range(0, 1);
      bus.id_rs1 = 5'($urandom_range(0, 3)); bus.id_rs2 = 5'($urandom_range(0, 3)); bus.id_rd = 5'($urandom_range(0, 3));
      bus.id_pc = $urandom; bus.id_ext = $urandom; bus.id_rs1_data = $urandom; bus.id_rs2_data = $urandom;
      bus.id_alua_sel = 2'($urandom); bus.id_alub_sel = 2'($urandom); bus.id_wd_sel = 2'($urandom); bus.id_alu_op = 4'($urandom);
      bus.ex_alu_result = $urandom;
      bus.ex_branch_taken = exp_q.is_branch && ($urandom_range(0, 3) == 0);
      bus.mem_rd = 5'($urandom_range(0, 3)); bus.mem_rf_we = $urandom_range(0, 1); bus.mem_fwd_data = $urandom;
      bus.wb_rd = 5'($urandom_range(0, 3));  bus.wb_rf_we = $urandom_range(0, 1);  bus.wb_wd = $urandom;
      rst = ($urandom_range(0, 49) == 0);
      #1;
      hz = ref_hazard();
      exp_stall = hz && !bus.ex_branch_taken && !rst;
      n_total++;
      if (bus.stall_id !== exp_stall) $display("FAIL rand_stall cycle %0d got %b exp %b", c, bus.stall_id, exp_stall);
      else n_pass++;
      nxt = '0;
      if (!rst && !bus.ex_branch_taken && !hz) begin
        nxt.valid = bus.id_valid; nxt.is_load = bus.id_is_load;
        nxt.rf_we = bus.id_valid ? bus.id_rf_we : 1'b0;
        nxt.ram_we = bus.id_valid ? bus.id_ram_we : 1'b0;
        nxt.is_branch = bus.id_is_branch; nxt.pc = bus.id_pc; nxt.ext = bus.id_ext;
        nxt.rs1 = ref_operand(bus.id_rs1, bus.id_rs1_data);
        nxt.rs2 = ref_operand(bus.id_rs2, bus.id_rs2_data);
        nxt.rd = bus.id_rd; nxt.alua = bus.id_alua_sel; nxt.alub = bus.id_alub_sel;
        nxt.wd = bus.id_wd_sel; nxt.op = bus.id_alu_op;
      end
      tick();
      n_total++;
      if (got !== nxt) $display("FAIL rand_ex_regs cycle %0d got %h exp %h", c, got, nxt);
      else n_pass++;
      exp_q = nxt;
    end
    rst = 0;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_ex_forward();
    test_priority();
    test_load_use();
    test_flush();
    test_midstall_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
